np_core: RTL and testbench

- Multicycle 32-bit accumulator processor ("np") driving one external single-port synchronous memory of 2^ADDRSIZE words.
- Fetches, decodes and executes one instruction at a time.
- Asserts halt when it executes HALT; the system bench stops on halt.
- Top-level CPU of the np system; the memory is a separate block that shares clk and reset.

---
 rtl/np_pkg.sv | 33 +++
 rtl/np_alu.sv | 32 +++
 rtl/np_core.sv | 174 +++++++++++++++++
 tb/tb_np_core.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/np_pkg.sv
// Shared definitions for the np accumulator processor: default sizes,
// opcode encodings and the control state type.
package np_pkg;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_ADDRSIZE = 12;

    localparam logic [3:0] OP_HALT  = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_XOR   = 4'h7;
    localparam logic [3:0] OP_NOT   = 4'h8;
    localparam logic [3:0] OP_SHL   = 4'h9;
    localparam logic [3:0] OP_SHR   = 4'hA;
    localparam logic [3:0] OP_JMP   = 4'hB;
    localparam logic [3:0] OP_JZ    = 4'hC;
    localparam logic [3:0] OP_JN    = 4'hD;
    localparam logic [3:0] OP_LDI   = 4'hE;
    localparam logic [3:0] OP_NOP   = 4'hF;

    typedef enum logic [2:0] {
        ST_FETCH      = 3'd0,
        ST_FETCH_WAIT = 3'd1,
        ST_EXEC       = 3'd2,
        ST_MEM_WAIT   = 3'd3,
        ST_HALTED     = 3'd4
    } state_t;

endpackage

// File: rtl/np_alu.sv
// Combinational accumulator datapath: produces the new accumulator value for
// every opcode that writes A; other opcodes pass A through unchanged.
module np_alu
    import np_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] operand,
    input  logic [3:0]       opcode,
    output logic [WIDTH-1:0] result
);

    // Result select; all arithmetic wraps modulo 2^WIDTH.
    always_comb begin
        result = a;
        case (opcode)
            OP_LOAD: result = operand;
            OP_LDI:  result = operand;
            OP_ADD:  result = a + operand;
            OP_SUB:  result = a - operand;
            OP_AND:  result = a & operand;
            OP_OR:   result = a | operand;
            OP_XOR:  result = a ^ operand;
            OP_NOT:  result = ~a;
            OP_SHL:  result = {a[WIDTH-2:0], 1'b0};
            OP_SHR:  result = {1'b0, a[WIDTH-1:1]};
            default: result = a;
        endcase
    end

endmodule

// File: rtl/np_core.sv
// Multicycle accumulator CPU: fetch / decode / execute against one external
// synchronous-read memory. Bus outputs are registered from next-state values.
module np_core
    import np_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int ADDRSIZE = DEF_ADDRSIZE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDTH-1:0]    dataIn,
    output logic [WIDTH-1:0]    dataOut,
    output logic [ADDRSIZE-1:0] address,
    output logic                wr,
    output logic                halt
);

    state_t              state_r;
    state_t              state_s;
    logic [ADDRSIZE-1:0] pc_r;
    logic [ADDRSIZE-1:0] pc_s;
    logic [3:0]          ir_op_r;
    logic [3:0]          ir_op_s;
    logic [ADDRSIZE-1:0] ir_addr_r;
    logic [ADDRSIZE-1:0] ir_addr_s;
    logic [WIDTH-1:0]    acc_r;
    logic [WIDTH-1:0]    acc_s;
    logic [WIDTH-1:0]    imm_s;
    logic [WIDTH-1:0]    operand_s;
    logic [WIDTH-1:0]    alu_result_s;
    logic [ADDRSIZE-1:0] address_r;
    logic [ADDRSIZE-1:0] address_s;
    logic                wr_r;
    logic                wr_s;
    logic                halt_r;
    logic                halt_s;

    assign imm_s = {{(WIDTH-ADDRSIZE){1'b0}}, ir_addr_r};

    // ALU operand: memory data while waiting on a load, else the zero-extended immediate.
    always_comb begin
        if (state_r == ST_MEM_WAIT) begin
            operand_s = dataIn;
        end else begin
            operand_s = imm_s;
        end
    end

    np_alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .a      (acc_r),
        .operand(operand_s),
        .opcode (ir_op_r),
        .result (alu_result_s)
    );

    // Next-state, PC, IR and accumulator updates.
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        ir_op_s   = ir_op_r;
        ir_addr_s = ir_addr_r;
        acc_s     = acc_r;
        case (state_r)
            ST_FETCH: begin
                state_s = ST_FETCH_WAIT;
            end
            ST_FETCH_WAIT: begin
                // Only the opcode and address fields of the instruction word matter.
                ir_op_s   = dataIn[WIDTH-1 -: 4];
                ir_addr_s = dataIn[ADDRSIZE-1:0];
                pc_s      = pc_r + ADDRSIZE'(1);
                state_s   = ST_EXEC;
            end
            ST_EXEC: begin
                case (ir_op_r)
                    OP_HALT:  state_s = ST_HALTED;
                    OP_LOAD:  state_s = ST_MEM_WAIT;
                    OP_ADD:   state_s = ST_MEM_WAIT;
                    OP_SUB:   state_s = ST_MEM_WAIT;
                    OP_AND:   state_s = ST_MEM_WAIT;
                    OP_OR:    state_s = ST_MEM_WAIT;
                    OP_XOR:   state_s = ST_MEM_WAIT;
                    OP_STORE: state_s = ST_FETCH;
                    OP_NOT, OP_SHL, OP_SHR, OP_LDI: begin
                        acc_s   = alu_result_s;
                        state_s = ST_FETCH;
                    end
                    OP_JMP: begin
                        pc_s    = ir_addr_r;
                        state_s = ST_FETCH;
                    end
                    OP_JZ: begin
                        if (acc_r == {WIDTH{1'b0}}) begin
                            pc_s = ir_addr_r;
                        end else begin
                            pc_s = pc_r;
                        end
                        state_s = ST_FETCH;
                    end
                    OP_JN: begin
                        if (acc_r[WIDTH-1]) begin
                            pc_s = ir_addr_r;
                        end else begin
                            pc_s = pc_r;
                        end
                        state_s = ST_FETCH;
                    end
                    OP_NOP:  state_s = ST_FETCH;
                    default: state_s = ST_FETCH;
                endcase
            end
            ST_MEM_WAIT: begin
                acc_s   = alu_result_s;
                state_s = ST_FETCH;
            end
            ST_HALTED: begin
                state_s = ST_HALTED;
            end
            default: begin
                state_s = ST_FETCH;
            end
        endcase
    end

    // Bus values for the cycle being entered, so the outputs can be registered.
    always_comb begin
        case (state_s)
            ST_EXEC:     address_s = ir_addr_s;
            ST_MEM_WAIT: address_s = ir_addr_s;
            default:     address_s = pc_s;
        endcase
        if ((state_s == ST_EXEC) && (ir_op_s == OP_STORE)) begin
            wr_s = 1'b1;
        end else begin
            wr_s = 1'b0;
        end
        if (state_s == ST_HALTED) begin
            halt_s = 1'b1;
        end else begin
            halt_s = 1'b0;
        end
    end

    // State and output registers; reset also kills an in-flight write at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_FETCH;
            pc_r      <= {ADDRSIZE{1'b0}};
            ir_op_r   <= 4'h0;
            ir_addr_r <= {ADDRSIZE{1'b0}};
            acc_r     <= {WIDTH{1'b0}};
            address_r <= {ADDRSIZE{1'b0}};
            wr_r      <= 1'b0;
            halt_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            pc_r      <= pc_s;
            ir_op_r   <= ir_op_s;
            ir_addr_r <= ir_addr_s;
            acc_r     <= acc_s;
            address_r <= address_s;
            wr_r      <= wr_s;
            halt_r    <= halt_s;
        end
    end

    assign dataOut = acc_r;
    assign address = address_r;
    assign wr      = wr_r;
    assign halt    = halt_r;

endmodule

// File: tb/tb_np_core.sv
// Bench for np_core: an instruction-level model expands each program into the
// expected per-cycle bus trace and final memory image, compared every cycle.
module tb_np_core;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dataIn;
    logic [31:0] dataOut;
    logic [11:0] address;
    logic        wr;
    logic        halt;

    np_core dut (
        .clk    (clk),
        .reset  (reset),
        .dataIn (dataIn),
        .dataOut(dataOut),
        .address(address),
        .wr     (wr),
        .halt   (halt)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:4095];
    logic [31:0] mm  [0:4095];
    logic        load_all;

    // Synchronous memory with registered read; load_all copies the model image in.
    always @(posedge clk) begin
        if (load_all) begin
            for (int i = 0; i < 4096; i++) mem[i] <= mm[i];
        end else if (wr) begin
            mem[address] <= dataOut;
        end
        dataIn <= mem[address];
    end

    typedef struct {
        logic [11:0] addr;
        bit          chk_addr;
        bit          wr;
        bit          halt;
        logic [31:0] dout;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc;
    int   first_halt;
    bit   chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push(input logic [11:0] a, input bit ca, input bit w,
                                 input bit h, input logic [31:0] d);
        exp_t x;
        x.addr = a; x.chk_addr = ca; x.wr = w; x.halt = h; x.dout = d;
        q.push_back(x);
    endfunction

    // Instruction-set model: runs the program in mm and emits one entry per bus cycle.
    task automatic model_run();
        logic [11:0] pc;
        logic [31:0] acc;
        logic [31:0] ir;
        logic [31:0] m;
        logic [3:0]  op;
        logic [11:0] opa;
        pc  = 12'd0;
        acc = 32'd0;
        q.delete();
        for (int n = 0; n < 200; n++) begin
            ir  = mm[pc];
            op  = ir[31:28];
            opa = ir[11:0];
            push(pc, 1'b1, 1'b0, 1'b0, acc);
            push(pc, 1'b0, 1'b0, 1'b0, acc);
            pc = pc + 12'd1;
            if (op == 4'h0) begin
                push(opa, 1'b0, 1'b0, 1'b0, acc);
                push(pc, 1'b0, 1'b0, 1'b1, acc);
                push(pc, 1'b0, 1'b0, 1'b1, acc);
                return;
            end else if (op == 4'h2) begin
                push(opa, 1'b1, 1'b1, 1'b0, acc);
                mm[opa] = acc;
            end else if (op <= 4'h7) begin
                push(opa, 1'b1, 1'b0, 1'b0, acc);
                push(opa, 1'b0, 1'b0, 1'b0, acc);
                m = mm[opa];
                case (op)
                    4'h1:    acc = m;
                    4'h3:    acc = acc + m;
                    4'h4:    acc = acc - m;
                    4'h5:    acc = acc & m;
                    4'h6:    acc = acc | m;
                    default: acc = acc ^ m;
                endcase
            end else begin
                push(opa, 1'b0, 1'b0, 1'b0, acc);
                case (op)
                    4'h8: acc = ~acc;
                    4'h9: acc = acc << 1;
                    4'hA: acc = acc >> 1;
                    4'hB: pc = opa;
                    4'hC: if (acc == 32'd0) pc = opa;
                    4'hD: if (acc[31]) pc = opa;
                    4'hE: acc = {20'd0, opa};
                    default: ;
                endcase
            end
        end
    endtask

    // Per-cycle comparison of the DUT bus against the model trace.
    always @(negedge clk) begin
        if (chk_en && q.size() > 0) begin
            e = q.pop_front();
            chk("wr", {31'd0, wr}, {31'd0, e.wr});
            chk("halt", {31'd0, halt}, {31'd0, e.halt});
            chk("dataOut", dataOut, e.dout);
            if (e.chk_addr) chk("address", {20'd0, address}, {20'd0, e.addr});
            if (halt === 1'b1 && first_halt < 0) first_halt = cyc;
            cyc++;
        end
    end

    task automatic clear_mm();
        for (int i = 0; i < 4096; i++) mm[i] = 32'd0;
    endtask

    task automatic put(input int a, input logic [3:0] op, input logic [11:0] opr);
        mm[a] = {op, 16'h0000, opr};
    endtask

    task automatic load_mem();
        load_all = 1'b1;
        @(posedge clk);
        #1 load_all = 1'b0;
    endtask

    // Release reset, follow the trace to its end, then compare the memory image.
    task automatic run(input int budget);
        int bad;
        int first_bad;
        cyc = 0;
        first_halt = -1;
        @(posedge clk);
        #1 reset = 1'b1;
        chk_en = 1'b1;
        for (int i = 0; i < budget && q.size() > 0; i++) @(posedge clk);
        chk_en = 1'b0;
        chk("trace_left", q.size(), 32'd0);
        q.delete();
        #1;
        bad = 0;
        first_bad = 0;
        for (int i = 0; i < 4096; i++) begin
            if (mem[i] !== mm[i]) begin
                if (bad == 0) first_bad = i;
                bad++;
            end
        end
        chk($sformatf("mem_image first_diff@%0h", first_bad), bad, 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        logic [3:0] op;
        logic [11:0] opr;
        reset    = 1'b0;
        load_all = 1'b0;

        // Reset state with HALT at address 0.
        clear_mm();
        load_mem();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_wr", {31'd0, wr}, 32'd0);
            chk("rst_addr", {20'd0, address}, 32'd0);
            chk("rst_halt", {31'd0, halt}, 32'd0);
            chk("rst_dout", dataOut, 32'd0);
        end
        model_run();
        run(50);
        chk("rst_halt_cycle", first_halt, 32'd3);

        // LOAD / ADD / STORE.
        clear_mm();
        mm[100] = 32'd5; mm[101] = 32'd7;
        put(0, 4'h1, 12'd100); put(1, 4'h3, 12'd101); put(2, 4'h2, 12'd102); put(3, 4'h0, 12'd0);
        load_mem();
        model_run();
        chk("model_las", mm[102], 32'd12);
        run(100);
        chk("las_mem102", mem[102], 32'd12);
        chk("las_halt_cycle", first_halt, 32'd14);

        // Logic and shifts: ~((0xF0F ^ 0xFFF) << 1).
        clear_mm();
        mm[12'h050] = 32'h0000_0FFF;
        put(0, 4'hE, 12'hF0F); put(1, 4'h7, 12'h050); put(2, 4'h9, 12'h000);
        put(3, 4'h8, 12'h000); put(4, 4'h2, 12'd200); put(5, 4'h0, 12'h000);
        load_mem();
        model_run();
        chk("model_logic", mm[200], 32'hFFFF_FE1F);
        run(100);
        chk("logic_mem200", mem[200], 32'hFFFF_FE1F);

        // Branches: JZ taken, JZ untaken, JN taken on a negative accumulator.
        clear_mm();
        mm[12'h060] = 32'h8000_0000;
        mm[300] = 32'hAAAA_AAAA; mm[301] = 32'hAAAA_AAAA;
        put(0, 4'hE, 12'd0);  put(1, 4'hC, 12'd10); put(2, 4'h0, 12'd0);
        put(10, 4'hE, 12'd1); put(11, 4'hC, 12'd20); put(12, 4'h2, 12'd300);
        put(13, 4'h1, 12'h060); put(14, 4'hD, 12'd30); put(15, 4'h0, 12'd0);
        put(20, 4'h0, 12'd0); put(30, 4'h2, 12'd301); put(31, 4'h0, 12'd0);
        load_mem();
        model_run();
        chk("model_br300", mm[300], 32'd1);
        run(200);
        chk("br_mem300", mem[300], 32'd1);
        chk("br_mem301", mem[301], 32'h8000_0000);
        chk("br_halt_cycle", first_halt, 32'd28);

        // Arithmetic wrap and PC wrap 4095 -> 0.
        clear_mm();
        mm[12'h500] = 32'hFFFF_FFFF; mm[12'h501] = 32'd1;
        mm[12'h502] = 32'h5555_5555; mm[12'h503] = 32'h5555_5555;
        put(0, 4'hD, 12'd16);  put(1, 4'h1, 12'h500); put(2, 4'h3, 12'h501);
        put(3, 4'h2, 12'h502); put(4, 4'hE, 12'h000); put(5, 4'h4, 12'h501);
        put(6, 4'h2, 12'h503); put(7, 4'hB, 12'hFFF); put(4095, 4'hF, 12'h000);
        put(16, 4'hE, 12'd7);  put(17, 4'h2, 12'h504); put(18, 4'h0, 12'd0);
        load_mem();
        model_run();
        run(300);
        chk("wrap_add", mem[12'h502], 32'd0);
        chk("wrap_sub", mem[12'h503], 32'hFFFF_FFFF);
        chk("wrap_pc", mem[12'h504], 32'd7);

        // Reset asserted during the STORE execute cycle.
        clear_mm();
        mm[12'h600] = 32'hDEAD_BEEF;
        put(0, 4'hE, 12'h123); put(1, 4'h2, 12'h600); put(2, 4'h0, 12'd0);
        load_mem();
        @(posedge clk);
        #1 reset = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (wr === 1'b1) found = 1'b1;
        end
        chk("midst_seen", {31'd0, found}, 32'd1);
        reset = 1'b0;
        #1;
        chk("midst_wr", {31'd0, wr}, 32'd0);
        chk("midst_halt", {31'd0, halt}, 32'd0);
        chk("midst_addr", {20'd0, address}, 32'd0);
        @(posedge clk);
        #1 chk("midst_mem", mem[12'h600], 32'hDEAD_BEEF);
        model_run();
        run(100);
        chk("midst_rerun", mem[12'h600], 32'h0000_0123);

        // Random programs in 0..47 operating on data at 0x800..0x81F.
        for (int t = 0; t < 10; t++) begin
            clear_mm();
            for (int i = 0; i < 32; i++) mm[12'h800 + i] = $urandom;
            for (int i = 0; i < 47; i++) begin
                op = 4'($urandom_range(15, 1));
                if ($urandom_range(24, 0) == 0) op = 4'h0;
                if (op <= 4'h7) opr = 12'h800 + 12'($urandom_range(31, 0));
                else if (op >= 4'hB && op <= 4'hD) opr = 12'($urandom_range(47, 0));
                else opr = 12'($urandom);
                mm[i] = {op, 16'($urandom), opr};
            end
            load_mem();
            model_run();
            run(1000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
